// File: rtl/ft245sync_dev_pkg.sv
// Shared constants for the FT245 SyncFIFO device model:
// pin polarity, error flag bit positions and the byte type.
package ft245sync_dev_pkg;

    localparam logic PIN_ON  = 1'b0;
    localparam logic PIN_OFF = 1'b1;

    localparam int ERR_RD_EMPTY = 0;
    localparam int ERR_WR_FULL  = 1;
    localparam int ERR_WR_OE    = 2;
    localparam int ERR_W        = 3;

    typedef logic [7:0] byte_t;

    function automatic logic asserted(logic pin_n);
        return pin_n == PIN_ON;
    endfunction

endpackage

// File: rtl/ft245sync_dev_if.sv
// FT245 SyncFIFO pins plus the host-side byte streams of the device model.
interface ft245sync_dev_if;
    import ft245sync_dev_pkg::*;

    logic        i_pin_oe_n;
    logic        i_pin_rd_n;
    logic        i_pin_wr_n;
    logic        i_pin_siwu;
    byte_t       i_pin_data;
    byte_t       o_pin_data;
    logic        o_pin_data_oe;
    logic        o_pin_rxf_n;
    logic        o_pin_txe_n;
    byte_t       i_h2d_data;
    logic        i_h2d_valid;
    logic        o_h2d_ready;
    byte_t       o_d2h_data;
    logic        o_d2h_valid;
    logic        i_d2h_ready;
    logic [ERR_W-1:0] o_err;

    modport slave (
        input  i_pin_oe_n, i_pin_rd_n, i_pin_wr_n, i_pin_siwu, i_pin_data,
        output o_pin_data, o_pin_data_oe, o_pin_rxf_n, o_pin_txe_n,
        input  i_h2d_data, i_h2d_valid,
        output o_h2d_ready,
        output o_d2h_data, o_d2h_valid,
        input  i_d2h_ready,
        output o_err
    );

    modport master (
        output i_pin_oe_n, i_pin_rd_n, i_pin_wr_n, i_pin_siwu, i_pin_data,
        input  o_pin_data, o_pin_data_oe, o_pin_rxf_n, o_pin_txe_n,
        output i_h2d_data, i_h2d_valid,
        input  o_h2d_ready,
        input  o_d2h_data, o_d2h_valid,
        output i_d2h_ready,
        input  o_err
    );

endinterface

// File: rtl/ft245sync_dev_byte_fifo.sv
// Circular byte FIFO with a look-ahead count used for registered status flags.
module ft245sync_dev_byte_fifo
    import ft245sync_dev_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  byte_t                      din,
    input  logic                       pop,
    output byte_t                      dout,
    output logic [$clog2(DEPTH):0]     count,
    output logic [$clog2(DEPTH):0]     count_next
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    byte_t          mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;

    // Callers only push when not full and pop when not empty.
    assign count_next = count + CW'(push) - CW'(pop);
    assign dout       = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_next;
        end
    end

endmodule

// File: rtl/ft245sync_dev.sv
// Device-side FT245 SyncFIFO model: answers OE#/RD#/WR#, drives RXF#/TXE#
// and buffers bytes between the pins and the host valid/ready streams.
module ft245sync_dev
    import ft245sync_dev_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic            i_clk,
    input  logic            i_rst,
    ft245sync_dev_if.slave  bus
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic            oe;
    logic            rd;
    logic            wr;
    logic            h2d_push;
    logic            h2d_pop;
    logic            d2h_push;
    logic            d2h_pop;
    logic [CW-1:0]   h2d_count;
    logic [CW-1:0]   h2d_next;
    logic [CW-1:0]   d2h_count;
    logic [CW-1:0]   d2h_next;
    logic [ERR_W-1:0] err;
    logic [ERR_W-1:0] err_set;
    logic            rxf_n;
    logic            txe_n;
    logic            unused_siwu;

    assign unused_siwu = bus.i_pin_siwu;

    assign oe = asserted(bus.i_pin_oe_n);
    assign rd = asserted(bus.i_pin_rd_n);
    assign wr = asserted(bus.i_pin_wr_n);

    assign bus.o_h2d_ready = (h2d_count != FULL);
    assign bus.o_d2h_valid = (d2h_count != '0);

    assign h2d_push = bus.i_h2d_valid && bus.o_h2d_ready;
    assign h2d_pop  = rd && oe && (h2d_count != '0);
    assign d2h_push = wr && !oe && (d2h_count != FULL);
    assign d2h_pop  = bus.o_d2h_valid && bus.i_d2h_ready;

    always_comb begin
        err_set               = '0;
        err_set[ERR_RD_EMPTY] = rd && oe && (h2d_count == '0);
        err_set[ERR_WR_FULL]  = wr && !oe && (d2h_count == FULL);
        // A write under bus contention is reported only as contention.
        err_set[ERR_WR_OE]    = wr && oe;
    end

    ft245sync_dev_byte_fifo #(.DEPTH(DEPTH)) u_h2d (
        .clk        (i_clk),
        .rst        (i_rst),
        .push       (h2d_push),
        .din        (bus.i_h2d_data),
        .pop        (h2d_pop),
        .dout       (bus.o_pin_data),
        .count      (h2d_count),
        .count_next (h2d_next)
    );

    ft245sync_dev_byte_fifo #(.DEPTH(DEPTH)) u_d2h (
        .clk        (i_clk),
        .rst        (i_rst),
        .push       (d2h_push),
        .din        (bus.i_pin_data),
        .pop        (d2h_pop),
        .dout       (bus.o_d2h_data),
        .count      (d2h_count),
        .count_next (d2h_next)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            err   <= '0;
            rxf_n <= PIN_OFF;
            txe_n <= PIN_OFF;
        end else begin
            err   <= err | err_set;
            rxf_n <= (h2d_next == '0);
            txe_n <= (d2h_next == FULL);
        end
    end

    assign bus.o_err         = err;
    assign bus.o_pin_rxf_n   = rxf_n;
    assign bus.o_pin_txe_n   = txe_n;
    assign bus.o_pin_data_oe = oe;

endmodule
